// File: rtl/ps2_pkg.sv
// Shared constants, event width and FSM state type for the PS/2 keyboard transmitter.
// Build macro PS2_TX_EXT_EN widens events to {ext, break, scan}.
package ps2_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam int         FRAME_BITS = 11;

`ifdef PS2_TX_EXT_EN
  localparam int EV_W = 10;
`else
  localparam int EV_W = 9;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } ps2_state_t;

  // Frame is sent LSB first: start(0), data[0..7], odd parity, stop(1).
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous event FIFO with count-based flags; a pop frees a slot for a push in the same cycle.
import ps2_pkg::*;

module ps2_tx_fifo #(
  parameter int WIDTH = 9,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             empty_nxt
);

  localparam int          DEPTH    = 2 ** AW;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != FULL_CNT) | do_pop);

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (do_pop && !do_push)
      count_nxt = count - 1'b1;
  end

  assign empty_nxt = (count_nxt == '0);
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: buffered key events become device-to-host frames.
// Build macro PS2_TX_EXT_EN adds the E0 prefix for extended keys.
//
//   state   | meaning
//   S_IDLE  | lines high, waiting for a buffered event
//   S_LOAD  | pick next byte of the event (E0 / F0 / scan) and latch its frame
//   S_SHIFT | clocking out the 11 frame bits, high phase then low phase per bit
//   S_GAP   | inter-byte idle with both lines high
import ps2_pkg::*;

module ps2_kbd_tx #(
  parameter int HALF_PERIOD = 8,
  parameter int GAP         = 16,
  parameter int FIFO_AW     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [EV_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            ps2_clk,
  output logic            ps2_data,
  output logic            busy,
  output logic            byte_done
);

  localparam int                CNT_W    = 16;
  localparam logic [CNT_W-1:0]  HP_LD    = CNT_W'(HALF_PERIOD - 1);
  // LOAD contributes one more idle cycle, so the whole inter-byte gap is GAP cycles.
  localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP - 2);
  localparam logic [3:0]        LAST_BIT = 4'(FRAME_BITS - 1);

  ps2_state_t state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [3:0]            bit_cnt, bit_n;
  logic                  phase_low, phase_n;
  logic [FRAME_BITS-1:0] sh, sh_n;
  logic [7:0]            scan_q, scan_n;
  logic                  pend_ext, ext_n;
  logic                  pend_brk, brk_n;
  logic                  pend_scan, scn_n;
  logic                  clk_n, data_n, done_n, busy_n;
  logic [7:0]            tx_byte;
  logic                  pop;
  logic [EV_W-1:0]       fifo_rd;
  logic                  fifo_empty, fifo_full, fifo_empty_nxt;

  ps2_tx_fifo #(.WIDTH(EV_W), .AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid & in_ready),
    .pop       (pop),
    .wr_data   (in_data),
    .rd_data   (fifo_rd),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .empty_nxt (fifo_empty_nxt)
  );

  assign in_ready = ~fifo_full;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    phase_n = phase_low;
    sh_n    = sh;
    scan_n  = scan_q;
    ext_n   = pend_ext;
    brk_n   = pend_brk;
    scn_n   = pend_scan;
    clk_n   = ps2_clk;
    data_n  = ps2_data;
    done_n  = 1'b0;
    pop     = 1'b0;
    tx_byte = '0;
    case (state)
      S_IDLE: begin
        clk_n  = 1'b1;
        data_n = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (pend_ext) begin
          tx_byte = EXT_CODE;
          ext_n   = 1'b0;
        end else if (pend_brk) begin
          tx_byte = BREAK_CODE;
          brk_n   = 1'b0;
        end else begin
          tx_byte = scan_q;
          scn_n   = 1'b0;
        end
        sh_n    = make_frame(tx_byte);
        clk_n   = 1'b1;
        data_n  = sh_n[0];
        cnt_n   = HP_LD;
        bit_n   = '0;
        phase_n = 1'b0;
        state_n = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (!phase_low) begin
          phase_n = 1'b1;
          clk_n   = 1'b0;
          cnt_n   = HP_LD;
        end else if (bit_cnt == LAST_BIT) begin
          clk_n   = 1'b1;
          data_n  = 1'b1;
          done_n  = 1'b1;
          cnt_n   = GAP_LD;
          state_n = S_GAP;
        end else begin
          phase_n = 1'b0;
          bit_n   = bit_cnt + 1'b1;
          sh_n    = {1'b1, sh[FRAME_BITS-1:1]};
          clk_n   = 1'b1;
          data_n  = sh[1];
          cnt_n   = HP_LD;
        end
      end
      S_GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (pend_scan) begin
          state_n = S_LOAD;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = S_LOAD;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (pop) begin
      scan_n = fifo_rd[7:0];
      brk_n  = fifo_rd[8];
      scn_n  = 1'b1;
`ifdef PS2_TX_EXT_EN
      ext_n  = fifo_rd[9];
`else
      ext_n  = 1'b0;
`endif
    end

    busy_n = (state_n != S_IDLE) | ~fifo_empty_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      phase_low <= 1'b0;
      sh        <= '0;
      scan_q    <= '0;
      pend_ext  <= 1'b0;
      pend_brk  <= 1'b0;
      pend_scan <= 1'b0;
      ps2_clk   <= 1'b1;
      ps2_data  <= 1'b1;
      busy      <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_n;
      phase_low <= phase_n;
      sh        <= sh_n;
      scan_q    <= scan_n;
      pend_ext  <= ext_n;
      pend_brk  <= brk_n;
      pend_scan <= scn_n;
      ps2_clk   <= clk_n;
      ps2_data  <= data_n;
      busy      <= busy_n;
      byte_done <= done_n;
    end
  end

endmodule
